seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
Serial bit-pattern transmitter: the generator end of the serial sequence-detection path. It accepts a parallel pattern word, a length and a repeat count. It then drives the pattern MSB-first, one bit per clock, on a single serial line that feeds a Moore sequence detector's d input. It provides a start/ready handshake, a done pulse and an abort, so benches and on-board stimulus logic can drive detectors with exact, repeatable bit streams.

Parameters:
MAX_LEN, 8, maximum pattern length in bits; the width of pattern.
LEN_W, 4, width of len; must satisfy 2**LEN_W > MAX_LEN.
REP_W, 4, width of reps.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
start  input  1  request a transmission; sampled only when ready=1.
abort  input  1  terminates an active transmission.
pattern  input  MAX_LEN  bits to send; the bits used are pattern[len_eff-1:0], sent MSB-first.
len  input  LEN_W  pattern length in bits.
reps  input  REP_W  number of pattern repetitions; 0 means repeat continuously until abort.
ready  output  1  high only in IDLE.
busy  output  1  high in SHIFT.
dout  output  1  serial data (registered).
dout_valid  output  1  high on every cycle in which dout carries a pattern bit.
done  output  1  one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, dout=0, dout_valid=0, done=0, busy=0, ready=1, and all internal registers cleared.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered, apart from ready and busy, which are decoded directly from state.
- len_eff:
  - len > MAX_LEN: clamp to MAX_LEN.
  - len = 0: start is ignored; stay in IDLE with no outputs changed.
- IDLE -> SHIFT: on an edge where start=1 and len!=0.
  - Capture pattern, len_eff and reps into internal registers.
  - Changes to the inputs after capture have no effect.
- Latency: the first bit, pattern[len_eff-1], appears on dout with dout_valid=1 in the cycle immediately after the capturing edge.
- SHIFT:
  - Each bit is held for exactly one cycle.
  - A bit counter counts down from len_eff-1 to 0.
  - When the counter reaches 0:
    - If the remaining repetition count is >1, or reps=0 (continuous): reload the counter and restart at the MSB on the next cycle, with no gap cycle.
    - Otherwise: go to DONE.
  - The repetition counter decrements once per completed pattern. In continuous mode it does not decrement.
- DONE: lasts exactly one cycle with done=1, dout=0, dout_valid=0, then returns to IDLE.
  - start is ignored in DONE.
  - The earliest restart is a start sampled in the following IDLE cycle.
- abort:
  - abort=1 on any edge while in SHIFT: go to IDLE on that edge, with dout=0, dout_valid=0 and no done pulse.
  - abort has no effect in IDLE or DONE.
- Simultaneous events:
  - abort and the last bit on the same edge: abort wins, so no done pulse.
  - start while busy: ignored.
- Reset mid-transmission: the transmission is dropped immediately and no done pulse is produced.
- In IDLE, dout=0 and dout_valid=0.
- Total stream length for finite reps: len_eff*reps valid cycles, followed by 1 done cycle.

Decomposition:
- Shared package seq_pkg holds:
  - localparam state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default MAX_LEN, LEN_W, REP_W;
  - the detector's target pattern constants, which both this block and the detector benches reuse.
- One sub-module is natural: seq_shift_reg. It is a loadable MAX_LEN-bit left-shift register with a parallel load, shift enable, an MSB output at the len_eff-1 tap, and a down-counter terminal flag.
- The FSM and the repetition counter stay in the top level.

Test Plan:
1. Reset, then start with pattern=8'h0B, len=4, reps=1 -> dout=1,0,1,1 with dout_valid=1 on cycles 1-4 after capture; done=1 on cycle 5; ready=1 on cycle 6.
2. pattern=8'h0B, len=4, reps=3 -> 12 contiguous valid bits 101110111011 with no gaps; exactly one done pulse.
3. reps=0, pattern=8'h05, len=3 -> continuous 101101...; assert abort after 7 bits -> the next cycle has dout_valid=0, done stays 0, ready=1.
4. len=0 with start -> no change; len=12 with pattern=8'hA5 -> clamped to 8, stream 10100101, then done.
5. start pulsed during SHIFT and during DONE -> ignored; the stream is unchanged; a new transmission begins only from IDLE.
6. rst=0 asserted mid-bit (asynchronously, between clock edges) in cycle 3 of a len=8 stream -> outputs go to their reset values immediately; no done pulse; a normal transmission works after release.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the serial sequence path: generator FSM encodings,
// default sizing, and the detector target pattern reused by detector benches.
package seq_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;
   localparam int DEF_REP_W   = 4;

   localparam logic [7:0] DET_PATTERN = 8'h0B;
   localparam logic [3:0] DET_LEN     = 4'd4;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register with a selectable MSB tap at len-1 and a
// bit down-counter whose terminal flag marks the last bit of a pattern.
module seq_shift_reg
   import seq_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic [MAX_LEN-1:0] din,
   input  logic [LEN_W-1:0]   len,
   output logic               tap,
   output logic               last
);

   logic [MAX_LEN-1:0] data_r;
   logic [LEN_W-1:0]   cnt_r;

   function automatic logic pick_bit(input logic [MAX_LEN-1:0] v, input logic [LEN_W-1:0] idx);
      logic r;
      r = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         r = (idx == LEN_W'(i)) ? v[i] : r;
      end
      return r;
   endfunction

   // Data and bit-counter registers: load restarts a pattern, shift advances one bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_r <= {MAX_LEN{1'b0}};
         cnt_r  <= {LEN_W{1'b0}};
      end else if (load) begin
         data_r <= din;
         cnt_r  <= len - LEN_W'(1);
      end else if (shift) begin
         data_r <= {data_r[MAX_LEN-2:0], 1'b0};
         cnt_r  <= cnt_r - LEN_W'(1);
      end else begin
         data_r <= data_r;
         cnt_r  <= cnt_r;
      end
   end

   assign tap  = pick_bit(data_r, len - LEN_W'(1));
   assign last = (cnt_r == {LEN_W{1'b0}});

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends pattern[len_eff-1:0] MSB-first, reps
// times (0 = until abort), with start/ready handshake and a done pulse.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int REP_W   = DEF_REP_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic [REP_W-1:0]   reps,
   output logic               ready,
   output logic               busy,
   output logic               dout,
   output logic               dout_valid,
   output logic               done
);

   logic [1:0]         state_r, state_nx_s;
   logic [MAX_LEN-1:0] pat_r, pat_nx_s, ld_data_s;
   logic [LEN_W-1:0]   len_r, len_nx_s, len_eff_s, ld_len_s;
   logic [REP_W-1:0]   reps_r, reps_nx_s;
   logic               dout_r, dout_nx_s, valid_r, valid_nx_s, done_r, done_nx_s;
   logic               load_s, shift_s, tap_s, last_s;

   function automatic logic pick_bit(input logic [MAX_LEN-1:0] v, input logic [LEN_W-1:0] idx);
      logic r;
      r = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         r = (idx == LEN_W'(i)) ? v[i] : r;
      end
      return r;
   endfunction

   assign len_eff_s = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

   // The shift register always holds the bits that follow the one on dout,
   // which is why it is loaded with the pattern pre-shifted by one.
   seq_shift_reg #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s),
      .shift (shift_s),
      .din   (ld_data_s),
      .len   (ld_len_s),
      .tap   (tap_s),
      .last  (last_s)
   );

   // Next-state and next-output decode for the IDLE/SHIFT/DONE sequencer
   always_comb begin
      state_nx_s = state_r;
      pat_nx_s   = pat_r;
      len_nx_s   = len_r;
      reps_nx_s  = reps_r;
      dout_nx_s  = 1'b0;
      valid_nx_s = 1'b0;
      done_nx_s  = 1'b0;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      ld_data_s  = {pat_r[MAX_LEN-2:0], 1'b0};
      ld_len_s   = len_r;
      case (state_r)
         ST_IDLE: begin
            if (start && (len != {LEN_W{1'b0}})) begin
               state_nx_s = ST_SHIFT;
               pat_nx_s   = pattern;
               len_nx_s   = len_eff_s;
               reps_nx_s  = reps;
               dout_nx_s  = pick_bit(pattern, len_eff_s - LEN_W'(1));
               valid_nx_s = 1'b1;
               load_s     = 1'b1;
               ld_data_s  = {pattern[MAX_LEN-2:0], 1'b0};
               ld_len_s   = len_eff_s;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_nx_s = ST_IDLE;
            end else if (!last_s) begin
               shift_s    = 1'b1;
               dout_nx_s  = tap_s;
               valid_nx_s = 1'b1;
            end else if ((reps_r == {REP_W{1'b0}}) || (reps_r > REP_W'(1))) begin
               // Back-to-back repetition: restart at the MSB with no gap cycle
               load_s     = 1'b1;
               dout_nx_s  = pick_bit(pat_r, len_r - LEN_W'(1));
               valid_nx_s = 1'b1;
               if (reps_r != {REP_W{1'b0}}) begin
                  reps_nx_s = reps_r - REP_W'(1);
               end else begin
                  reps_nx_s = reps_r;
               end
            end else begin
               state_nx_s = ST_DONE;
               done_nx_s  = 1'b1;
               reps_nx_s  = reps_r - REP_W'(1);
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, captured transfer parameters and registered serial outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         pat_r   <= {MAX_LEN{1'b0}};
         len_r   <= {LEN_W{1'b0}};
         reps_r  <= {REP_W{1'b0}};
         dout_r  <= 1'b0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         pat_r   <= pat_nx_s;
         len_r   <= len_nx_s;
         reps_r  <= reps_nx_s;
         dout_r  <= dout_nx_s;
         valid_r <= valid_nx_s;
         done_r  <= done_nx_s;
      end
   end

   assign ready      = (state_r == ST_IDLE);
   assign busy       = (state_r == ST_SHIFT);
   assign dout       = dout_r;
   assign dout_valid = valid_r;
   assign done       = done_r;

endmodule
